// File: rtl/coffer_pkg.sv
// Shared types and constants for the coffer lock sequencing controller.
package coffer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StOpen,
    StChange,
    StLockout
  } state_e;

  // Status LED patterns, active-low.
  localparam logic [7:0] LED_IDLE = 8'hFF;
  localparam logic [7:0] LED_OK   = 8'h7F;
  localparam logic [7:0] LED_ERR  = 8'hBF;
  localparam logic [7:0] LED_CHG  = 8'h3F;
  localparam logic [7:0] LED_LOCK = 8'h00;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // A switch value is a usable decimal digit.
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/coffer_timer.sv
// 32-bit saturating down-counter shared by the OPEN relock and LOCKOUT periods.
module coffer_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        freeze,
  output logic        expired
);

  logic [31:0] count_q, count_d;

  // Next count: a load wins, otherwise decrement towards 0 unless frozen.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (!freeze && (count_q != '0)) begin
      count_d = count_q - 32'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the edge on which the count steps to 0, so the owner leaves its state exactly
  // load_val edges after the load.
  assign expired = (count_q <= 32'd1);

endmodule

// File: rtl/coffer_access_ctrl.sv
// Sequencing controller for the two-digit coffer lock: digit entry, check, open,
// password change and lockout. Optional timed lockout exit: COFFER_LOCKOUT_TIMER_EN.
module coffer_access_ctrl #(
  parameter logic [3:0]  INIT_HI        = 4'd2,
  parameter logic [3:0]  INIT_LO        = 4'd2,
  parameter int unsigned MAX_ERR        = 3,
  parameter logic [31:0] OPEN_CYCLES    = 32'd250_000_000,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] switch_in,
  input  logic       digit_lo_p,
  input  logic       digit_hi_p,
  input  logic       confirm_p,
  input  logic       change_p,
  output logic [3:0] code_lo,
  output logic [3:0] code_hi,
  output logic [7:0] led,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] err_cnt
);

  import coffer_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  code_lo_q, code_lo_d, code_hi_q, code_hi_d;
  logic [7:0]  pw_q, pw_d;
  logic [7:0]  led_q, led_d;
  logic        unlocked_q, unlocked_d;
  logic        alarm_q, alarm_d;
  logic [2:0]  err_q, err_d;
  logic [3:0]  err_inc;
  logic        do_confirm, do_change, do_hi, do_lo;
  logic        tmr_load, tmr_freeze, tmr_expired;
  logic [31:0] tmr_load_val;

  // Only the highest-priority pulse of a cycle acts.
  assign do_confirm = confirm_p;
  assign do_change  = !confirm_p && change_p;
  assign do_hi      = !confirm_p && !change_p && digit_hi_p;
  assign do_lo      = !confirm_p && !change_p && !digit_hi_p && digit_lo_p;

  // Next-state, register updates and timer control for the lock sequence.
  always_comb begin
    state_d    = state_q;
    code_lo_d  = code_lo_q;
    code_hi_d  = code_hi_q;
    pw_d       = pw_q;
    led_d      = led_q;
    unlocked_d = unlocked_q;
    alarm_d    = alarm_q;
    err_d      = err_q;
    err_inc    = {1'b0, err_q} + 4'd1;
    tmr_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (do_confirm) begin
          state_d = StCheck;
        end else begin
          if (do_hi && digit_ok(switch_in)) code_hi_d = switch_in;
          if (do_lo && digit_ok(switch_in)) code_lo_d = switch_in;
        end
      end
      StCheck: begin
        if ({code_hi_q, code_lo_q} == pw_q) begin
          state_d    = StOpen;
          err_d      = '0;
          led_d      = LED_OK;
          unlocked_d = 1'b1;
          tmr_load   = 1'b1;
        end else if (err_inc < 4'(MAX_ERR)) begin
          state_d = StIdle;
          err_d   = err_inc[2:0];
          led_d   = LED_ERR;
        end else begin
          state_d = StLockout;
          err_d   = 3'(MAX_ERR);
          led_d   = LED_LOCK;
          alarm_d = 1'b1;
`ifdef COFFER_LOCKOUT_TIMER_EN
          tmr_load = 1'b1;
`endif
        end
      end
      StOpen: begin
        if (do_confirm || tmr_expired) begin
          state_d    = StIdle;
          code_lo_d  = '0;
          code_hi_d  = '0;
          unlocked_d = 1'b0;
          led_d      = LED_IDLE;
        end else if (do_change) begin
          state_d = StChange;
          led_d   = LED_CHG;
        end
      end
      StChange: begin
        if (do_confirm || do_change) begin
          // Confirm commits the displayed digits; change aborts. Both restart the relock period.
          if (do_confirm) pw_d = {code_hi_q, code_lo_q};
          state_d  = StOpen;
          led_d    = LED_OK;
          tmr_load = 1'b1;
        end else begin
          if (do_hi && digit_ok(switch_in)) code_hi_d = switch_in;
          if (do_lo && digit_ok(switch_in)) code_lo_d = switch_in;
        end
      end
      StLockout: begin
`ifdef COFFER_LOCKOUT_TIMER_EN
        if (tmr_expired) begin
          state_d   = StIdle;
          err_d     = '0;
          alarm_d   = 1'b0;
          led_d     = LED_IDLE;
          code_lo_d = '0;
          code_hi_d = '0;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      code_lo_q  <= '0;
      code_hi_q  <= '0;
      pw_q       <= {INIT_HI, INIT_LO};
      led_q      <= LED_IDLE;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      code_lo_q  <= code_lo_d;
      code_hi_q  <= code_hi_d;
      pw_q       <= pw_d;
      led_q      <= led_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      err_q      <= err_d;
    end
  end

  // Lockout load only happens when the timed exit is built in.
  assign tmr_load_val = (state_d == StLockout) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  // OPEN and LOCKOUT are the only timed states; CHANGE holds the count.
  assign tmr_freeze   = !((state_q == StOpen) || (state_q == StLockout));

  coffer_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .freeze   (tmr_freeze),
    .expired  (tmr_expired)
  );

  assign code_lo  = code_lo_q;
  assign code_hi  = code_hi_q;
  assign led      = led_q;
  assign unlocked = unlocked_q;
  assign alarm    = alarm_q;
  assign err_cnt  = err_q;

endmodule

// File: doc/coffer_access_ctrl.md
# coffer_access_ctrl

Sequencing controller for the two-digit coffer lock. It sits between the debounced key pulses / 4-bit switch bank and the lock outputs (LEDs, 7-segment digit sources, unlock strobe). It owns the entry, check, open, password-change and lockout sequence, and it holds the stored password. The two 7-segment decoders and `key_debounce` stay outside this block; they consume `code_lo`/`code_hi` and feed the `*_p` pulses.

## Interface
Parameters:
- `INIT_HI`, 4'd2: tens digit of the power-up/reset password.
- `INIT_LO`, 4'd2: units digit of the power-up/reset password.
- `MAX_ERR`, 3: consecutive wrong checks that force LOCKOUT (legal range 1..7).
- `OPEN_CYCLES`, 32'd250_000_000: cycles in OPEN before automatic relock.
- `LOCKOUT_CYCLES`, 32'd500_000_000: lockout duration (used only with the macro).

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `switch_in`, in, 4: digit value from the switch bank.
- `digit_lo_p`, in, 1: one-cycle pulse; latch `switch_in` as the units digit.
- `digit_hi_p`, in, 1: one-cycle pulse; latch `switch_in` as the tens digit.
- `confirm_p`, in, 1: one-cycle pulse; submit, commit or relock, depending on state.
- `change_p`, in, 1: one-cycle pulse; enter or abort a password change (OPEN/CHANGE only).
- `code_lo`, out, 4: units digit currently shown on display 1.
- `code_hi`, out, 4: tens digit currently shown on display 2.
- `led`, out, 8: status LEDs, active-low.
- `unlocked`, out, 1: high while in OPEN.
- `alarm`, out, 1: high while in LOCKOUT.
- `err_cnt`, out, 3: consecutive wrong-check count.

## Operation
States: IDLE, CHECK, OPEN, CHANGE, LOCKOUT.

Reset values (any state, mid-sequence included):
- State = IDLE.
- `code_lo` = `code_hi` = 0.
- Stored password = {INIT_HI, INIT_LO}.
- `err_cnt` = 0, `led` = 8'hFF, `unlocked` = 0, `alarm` = 0.
- Timer cleared.

Digit entry (IDLE and CHANGE only):
- A digit pulse loads `switch_in` into `code_lo` or `code_hi`.
- Values greater than 9 are rejected: the register is unchanged.

Same-cycle priority: `confirm_p` > `change_p` > `digit_hi_p` > `digit_lo_p`. Only the highest-priority pulse acts; the others are dropped.

Transitions:
- IDLE, `confirm_p` → CHECK.
- CHECK (always exactly 1 cycle):
  - {code_hi, code_lo} equals the stored password → OPEN; `err_cnt` = 0; `led` = 8'h7F; `unlocked` = 1; timer loads OPEN_CYCLES.
  - Mismatch and `err_cnt`+1 < MAX_ERR → IDLE; `err_cnt` increments; `led` = 8'hBF.
  - Mismatch and `err_cnt`+1 == MAX_ERR → LOCKOUT; `err_cnt` = MAX_ERR; `led` = 8'h00; `alarm` = 1.
- OPEN:
  - `confirm_p` or timer reaches 0 → IDLE; `code_lo`/`code_hi` cleared; `unlocked` = 0; `led` = 8'hFF.
  - `change_p` → CHANGE; `led` = 8'h3F; `unlocked` stays 1.
- CHANGE:
  - Digits entered here overwrite `code_*`.
  - `confirm_p` → stored password = {code_hi, code_lo}, then OPEN; timer reloads.
  - `change_p` → OPEN with no commit; timer reloads.
  - The OPEN timer is frozen while in CHANGE.
- LOCKOUT:
  - All key pulses are ignored.
  - Exit is defined under Configuration.

Widths: the timer is 32 bits and counts down, saturating at 0. `err_cnt` saturates at MAX_ERR and never wraps.

## Timing
- Pulse at edge k: state and `code_*` update at edge k.
- Check result (`led`, `unlocked`, `alarm`, `err_cnt`) is registered at edge k+1. Latency from confirm to result is 2 edges.
- All outputs are registered. There are no combinational paths from input to output.
- OPEN auto-relock: IDLE is reached exactly OPEN_CYCLES cycles after entering OPEN, with no intervening CHANGE.
- A pulse arriving during CHECK is dropped.

## Configuration
`COFFER_LOCKOUT_TIMER_EN`:
- Defined: on entry to LOCKOUT the timer loads LOCKOUT_CYCLES. When it expires, the next state is IDLE with `err_cnt` = 0, `alarm` = 0, `led` = 8'hFF and `code_*` = 0.
- Undefined: LOCKOUT is permanent until `rst`. LOCKOUT_CYCLES is unused.

## Structure
- Package `coffer_pkg` holds:
  - The state enum.
  - LED constants: LED_IDLE 8'hFF, LED_OK 8'h7F, LED_ERR 8'hBF, LED_CHG 8'h3F, LED_LOCK 8'h00.
  - Digit max 4'd9.
- Sub-module `coffer_timer`: a 32-bit down-counter with load, freeze and `expired` ports. It is shared by OPEN and LOCKOUT, which are mutually exclusive.

## Test plan
- Reset, then set switches to 2 and pulse `digit_hi_p` and `digit_lo_p`, then `confirm_p` → 2 edges later `led` = 8'h7F, `unlocked` = 1, `err_cnt` = 0.
- Enter 3/5 and confirm twice (MAX_ERR = 3) → `led` = 8'hBF with `err_cnt` 1, then 2. Third wrong check → `led` = 8'h00, `alarm` = 1, and later correct entries are ignored.
- Open, `change_p`, enter 4/7, `confirm_p`, `confirm_p` (relock) → 4/7 unlocks and 2/2 fails. Then `rst` → 2/2 unlocks again.
- `switch_in` = 4'hC with `digit_lo_p` → `code_lo` unchanged. `confirm_p` and `digit_lo_p` in the same cycle → CHECK uses the old `code_lo`.
- OPEN_CYCLES = 10 → `unlocked` falls exactly 10 cycles after OPEN entry. CHANGE entered at cycle 5 and aborted at cycle 8 → relock 10 cycles after cycle 8.
- With `COFFER_LOCKOUT_TIMER_EN`, LOCKOUT_CYCLES = 20 → `alarm` high for 20 cycles, then IDLE with `err_cnt` = 0. Without the macro → still locked after 1000 cycles. `rst` mid-lockout → IDLE on the next edge.
